// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Tnew/Tuse encodings, scoreboard slot layout and hazard helpers.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 2;
  localparam int TUSE_W = 2;

  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [TNEW_W-1:0] tnew_t;
  typedef logic [TUSE_W-1:0] tuse_t;

  typedef struct packed {
    reg_idx_t waddr;
    tnew_t    tnew;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{waddr: '0, tnew: '0};

  function automatic logic slot_hit(
    reg_idx_t src,
    tuse_t    tuse,
    slot_t    s
  );
    return (src == s.waddr) && (tuse < s.tnew);
  endfunction

  // A zero source is $0 and can never be a real dependency.
  function automatic logic src_hazard(
    reg_idx_t src,
    tuse_t    tuse,
    slot_t    e,
    slot_t    m
  );
    return (src != '0) && (tuse != TUSE_NONE) &&
           (slot_hit(src, tuse, e) || slot_hit(src, tuse, m));
  endfunction

  function automatic tnew_t tnew_dec(tnew_t t);
    return (t == '0) ? '0 : t - tnew_t'(1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the D stage and the hazard controller.
// The master is the decode stage, the slave is the controller.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  reg_idx_t    rs_d;
  reg_idx_t    rt_d;
  tuse_t       tuse_rs_d;
  tuse_t       tuse_rt_d;
  reg_idx_t    waddr_d;
  tnew_t       tnew_d;
  logic        md_use_d;
  logic        md_start_e;
  logic        md_is_div_e;

  logic        stall_pc;
  logic        stall_fd;
  logic        flush_de;
  logic        md_busy;
  logic [31:0] stall_count;

  modport master (
    output rs_d, rt_d,
    output tuse_rs_d, tuse_rt_d,
    output waddr_d, tnew_d,
    output md_use_d,
    output md_start_e, md_is_div_e,
    input  stall_pc, stall_fd, flush_de,
    input  md_busy, stall_count
  );

  modport slave (
    input  rs_d, rt_d,
    input  tuse_rs_d, tuse_rt_d,
    input  waddr_d, tnew_d,
    input  md_use_d,
    input  md_start_e, md_is_div_e,
    output stall_pc, stall_fd, flush_de,
    output md_busy, stall_count
  );

endinterface

// File: rtl/mdu_busy_counter.sv
// Busy timer for the multi-cycle mult/div unit.
// A start always reloads, even if a previous op is still running.
module mdu_busy_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_MUL = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] LOAD_DIV = CNT_W'(DIV_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? LOAD_DIV : LOAD_MUL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller sitting beside decode.
// Tracks E/M Tnew slots and the mdu busy timer; stall is purely combinational.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  slot_t slot_e;
  slot_t slot_m;
  logic  busy;
  logic  stall_rs;
  logic  stall_rt;
  logic  stall_md;
  logic  stall;

  logic [31:0] stall_cnt;

  mdu_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.md_start_e),
    .is_div (hz.md_is_div_e),
    .busy   (busy)
  );

  always_comb begin
    stall_rs = src_hazard(hz.rs_d, hz.tuse_rs_d,
                          slot_e, slot_m);
    stall_rt = src_hazard(hz.rt_d, hz.tuse_rt_d,
                          slot_e, slot_m);
    stall_md = hz.md_use_d &
               (busy | hz.md_start_e);
    stall    = stall_rs | stall_rt | stall_md;
  end

  // A stalled D instruction re-enters next cycle, so E gets a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_e <= SLOT_EMPTY;
      slot_m <= SLOT_EMPTY;
    end else begin
      slot_m.waddr <= slot_e.waddr;
      slot_m.tnew  <= tnew_dec(slot_e.tnew);
      if (stall) begin
        slot_e <= SLOT_EMPTY;
      end else begin
        slot_e.waddr <= hz.waddr_d;
        slot_e.tnew  <= hz.tnew_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.stall_pc    = stall;
  assign hz.stall_fd    = stall;
  assign hz.flush_de    = stall;
  assign hz.md_busy     = busy;
  assign hz.stall_count = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// One task per scenario; expectations are hand-derived.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [1:0] urs, input logic [1:0] urt,
    input logic [4:0] wa, input logic [1:0] tn,
    input logic mdu
  );
    hz.rs_d      = rs;
    hz.rt_d      = rt;
    hz.tuse_rs_d = urs;
    hz.tuse_rt_d = urt;
    hz.waddr_d   = wa;
    hz.tnew_d    = tn;
    hz.md_use_d  = mdu;
  endtask

  task automatic set_nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
    hz.md_start_e  = 1'b0;
    hz.md_is_div_e = 1'b0;
  endtask

  task automatic do_reset();
    set_nop();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({hz.stall_pc, hz.stall_fd, hz.flush_de,
         hz.md_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got %b want 0000",
        {hz.stall_pc, hz.stall_fd, hz.flush_de, hz.md_busy});
    end
    checks++;
    if (hz.stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0",
        hz.stall_count);
    end
  endtask

  task automatic test_lw_use();
    do_reset();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0);
    #1;
    checks++;
    if (hz.stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL lw_issue stall got %b want 0", hz.stall_fd);
    end
    tick();
    set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd1, 1'b0);
    #1;
    checks++;
    if ({hz.stall_pc, hz.stall_fd, hz.flush_de} !== 3'b111) begin
      errors++;
      $display("FAIL lw_use stall got %b want 111",
        {hz.stall_pc, hz.stall_fd, hz.flush_de});
    end
    tick();
    #1;
    checks++;
    if (dut.slot_m.tnew !== 2'd1 || dut.slot_m.waddr !== 5'd1) begin
      errors++;
      $display("FAIL lw_m_slot got %0d/%0d want 1/1",
        dut.slot_m.waddr, dut.slot_m.tnew);
    end
    checks++;
    if (hz.stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL lw_resolved stall got %b want 0", hz.stall_fd);
    end
    checks++;
    if (hz.stall_count !== 32'd1) begin
      errors++;
      $display("FAIL lw_count got %0d want 1", hz.stall_count);
    end
    set_nop();
  endtask

  task automatic test_zero_reg();
    int n;
    do_reset();
    n = 0;
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 2'd1, 2'd0, 5'd3, 2'd1, 1'b0);
    #1;
    if (hz.stall_fd) n++;
    tick();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0);
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd1, 1'b0);
    #1;
    if (hz.stall_fd) n++;
    tick();
    #1;
    if (hz.stall_fd) n++;
    checks++;
    if (n != 0 || hz.stall_count !== 32'd0) begin
      errors++;
      $display("FAIL zero_reg stalls got %0d/%0d want 0/0",
        n, hz.stall_count);
    end
    set_nop();
  endtask

  task automatic run_branch(
    input logic [1:0] ptnew, input int want, input string nm
  );
    int n;
    do_reset();
    n = 0;
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, ptnew, 1'b0);
    tick();
    set_d(5'd6, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (hz.stall_fd) n++;
      tick();
    end
    checks++;
    if (n != want || hz.stall_count !== 32'(want)) begin
      errors++;
      $display("FAIL %s stalls got %0d/%0d want %0d",
        nm, n, hz.stall_count, want);
    end
    set_nop();
  endtask

  task automatic test_branch();
    run_branch(2'd1, 1, "alu_beq");
    run_branch(2'd2, 2, "lw_beq");
  endtask

  task automatic run_mdu(
    input logic div, input int want_st,
    input int want_bz, input string nm
  );
    int ns;
    int nb;
    do_reset();
    ns = 0;
    nb = 0;
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1);
    hz.md_start_e  = 1'b1;
    hz.md_is_div_e = div;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (hz.stall_fd) ns++;
      if (hz.md_busy) nb++;
      tick();
      hz.md_start_e = 1'b0;
    end
    checks++;
    if (ns != want_st) begin
      errors++;
      $display("FAIL %s_stall got %0d want %0d", nm, ns, want_st);
    end
    checks++;
    if (nb != want_bz) begin
      errors++;
      $display("FAIL %s_busy got %0d want %0d", nm, nb, want_bz);
    end
    checks++;
    if (hz.stall_count !== 32'(want_st)) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d",
        nm, hz.stall_count, want_st);
    end
    set_nop();
  endtask

  task automatic test_mdu();
    run_mdu(1'b1, 11, 10, "div");
    run_mdu(1'b0, 6, 5, "mult");
    do_reset();
    hz.md_start_e = 1'b1;
    hz.md_is_div_e = 1'b1;
    #1;
    checks++;
    if (hz.stall_fd !== 1'b0) begin
      errors++;
      $display("FAIL mdu_nouse stall got %b want 0", hz.stall_fd);
    end
    set_nop();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0);
    hz.md_start_e  = 1'b1;
    hz.md_is_div_e = 1'b1;
    tick();
    hz.md_start_e = 1'b0;
    set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd2, 2'd1, 1'b1);
    #1;
    checks++;
    if (hz.stall_fd !== 1'b1 || hz.md_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got %b%b want 11",
        hz.stall_fd, hz.md_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({hz.stall_fd, hz.flush_de, hz.md_busy} !== 3'b000 ||
        hz.stall_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_rst got %b cnt %0d want 000 cnt 0",
        {hz.stall_fd, hz.flush_de, hz.md_busy}, hz.stall_count);
    end
    checks++;
    if (dut.slot_e !== 7'd0 || dut.slot_m !== 7'd0) begin
      errors++;
      $display("FAIL mid_rst_slots got %h/%h want 0/0",
        dut.slot_e, dut.slot_m);
    end
    set_nop();
  endtask

  task automatic test_back_to_back();
    logic [4:0] wa [20];
    logic [1:0] tn [20];
    int n;
    int bad;
    do_reset();
    n = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      wa[i] = 5'(8 + (i % 8));
      tn[i] = 2'(i % 3);
      set_d(5'(24 + (i % 4)), 5'(28 + (i % 4)),
            2'd0, 2'd0, wa[i], tn[i], 1'b0);
      #1;
      if (hz.stall_fd) n++;
      tick();
      if (dut.slot_e.waddr !== wa[i] || dut.slot_e.tnew !== tn[i])
        bad++;
      if (i >= 1 && (dut.slot_m.waddr !== wa[i-1] ||
          dut.slot_m.tnew !== tnew_dec(tn[i-1])))
        bad++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL b2b_stall got %0d want 0", n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_slots got %0d bad want 0", bad);
    end
    set_nop();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_nop();
    test_reset();
    test_lw_use();
    test_zero_reg();
    test_branch();
    test_mdu();
    test_reset_mid_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Stall/flush controller for the 5-stage pipeline. It drives the F/D register hold (Stall_FD), the PC hold and the D/E bubble insertion. It keeps its own Tnew scoreboard for the E and M stages, and a busy counter for the multi-cycle mult/div unit. It sits beside the decode stage and consumes only D-stage decode results plus the E-stage mdu start strobe.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu start
DIV_CYC, 10, busy cycles after a div/divu start
CNT_W, 4, busy counter width; must hold DIV_CYC

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rs_D  in  5  rs field of instruction in D
rt_D  in  5  rt field of instruction in D
tuse_rs_D  in  2  cycles until rs is needed (0..2); 3 = rs not read
tuse_rt_D  in  2  same for rt
waddr_D  in  5  destination GPR of D instruction; 0 = none
tnew_D  in  2  Tnew of D instruction as seen once in E (lw=2, ALU=1, jal/lui-forwardable=0)
md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
md_start_E  in  1  one-cycle strobe: mult/div begins in E this cycle
md_is_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult
stall_pc  out  1  hold PC
stall_fd  out  1  hold F/D register (Stall_FD)
flush_de  out  1  load bubble into D/E register
md_busy  out  1  mdu counter nonzero
stall_count  out  32  saturating count of stalled cycles

Behaviour:
- State:
  - E slot {waddr_e[4:0], tnew_e[1:0]}
  - M slot {waddr_m, tnew_m}
  - md_cnt[CNT_W-1:0]
  - stall_count
- Reset clears all state to 0. All outputs are 0 in the cycle after reset.
- Stall condition is combinational from registered state and D inputs, with zero latency. stall = stall_rs | stall_rt | stall_md.
- stall_rs = rs_D!=0 & tuse_rs_D!=3 & ((rs_D==waddr_e & tuse_rs_D<tnew_e) | (rs_D==waddr_m & tuse_rs_D<tnew_m)). stall_rt is the same with rt.
- stall_md = md_use_D & (md_cnt!=0 | md_start_E).
- stall_pc = stall_fd = flush_de = stall.
- Scoreboard update on each clock:
  - M slot <= {waddr_e, tnew_e==0 ? 0 : tnew_e-1}.
  - E slot <= stall ? {0,0} (bubble) : {waddr_D, tnew_D}.
  - A W stage is not tracked, because W always forwards.
- MDU counter, with priority in this order:
  - reset;
  - md_start_E loads md_is_div_E ? DIV_CYC : MULT_CYC;
  - else if md_cnt!=0, decrement;
  - else hold.
  - md_busy = md_cnt!=0.
  - md_start_E while already busy reloads the counter. Upstream stalling prevents this; it is a legal no-error case.
- stall_count increments when stall=1 and saturates at 32'hFFFF_FFFF.
- Boundary conditions:
  - waddr 0 never causes a stall.
  - A match in both E and M slots is evaluated as an OR.
  - Reset mid-stall drops all hazards immediately: state clears and outputs are 0 next cycle.
  - Stall is never registered, so no extra bubble is inserted after the hazard resolves.

Decomposition:
- Shared package: TUSE_NONE=2'd3; TNEW widths; default MULT_CYC/DIV_CYC constants; reg-index width 5.
- One sub-module is natural: mdu_busy_counter (load/decrement/busy) with ports clk, reset, start, is_div, busy.

Test Plan:
- lw $1 in E (waddr_e=1, tnew_e=2); D has add reading rs=1, tuse_rs=1 -> stall=1 for exactly 1 cycle, flush_de=1. Next cycle M slot tnew_m=1, stall=0. stall_count=1.
- Same case with rs_D=0 or waddr=0 -> stall never asserts.
- ALU producer to $5 (tnew 1) followed by beq reading rt=5 (tuse 0) -> stall 1 cycle in E; next cycle M tnew 0, no stall. lw followed by beq -> 2 stall cycles.
- md_start_E with md_is_div_E=1, then mflo held in D -> stall asserted 11 cycles (start cycle plus 10 counts). md_busy falls 10 cycles after start. mult -> 6 stall cycles.
- Assert reset during a div busy period with lw hazard pending -> next cycle md_busy=0, stall=0, stall_count=0, both slots cleared.
- Back-to-back independent instructions (no register overlap, md_use_D=0) for 20 cycles -> stall stays 0. Slots mirror waddr_D/tnew_D delayed by 1 and 2 cycles with tnew decremented.
